// File: rtl/drone_mix_pkg.sv
// Shared types and constants for the quad-X motor mixer.
// Sign table, axis indices and accumulator width helper.
package drone_mix_pkg;

  typedef enum logic [2:0] {
    ST_DISARMED = 3'd0,
    ST_IDLE     = 3'd1,
    ST_MIX      = 3'd2,
    ST_COMMIT   = 3'd3,
    ST_FAILSAFE = 3'd4
  } state_t;

  localparam logic [1:0] AX_T = 2'd0;
  localparam logic [1:0] AX_P = 2'd1;
  localparam logic [1:0] AX_R = 2'd2;
  localparam logic [1:0] AX_Y = 2'd3;

  // Per motor {Y,R,P}; a set bit subtracts that axis.
  localparam logic [3:0][2:0] SIGN_SUB = {
    3'b001,
    3'b111,
    3'b010,
    3'b100
  };

  function automatic int acc_w(input int axis_w);
    return axis_w + 3;
  endfunction

endpackage

// File: rtl/mix_sat_accum.sv
// Shared signed load/add/subtract accumulator.
// Also presents the saturated value of the next accumulator state.
module mix_sat_accum
  import drone_mix_pkg::*;
#(
  parameter int AXIS_W    = 12,
  parameter int OUT_W     = 11,
  parameter int MOTOR_MIN = 100,
  parameter int MOTOR_MAX = 2000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     load,
  input  logic                     sub,
  input  logic [OUT_W-1:0]         thr,
  input  logic signed [AXIS_W-1:0] operand,
  output logic [OUT_W-1:0]         sat_next
);

  localparam int ACC_W = acc_w(AXIS_W);
  localparam logic signed [ACC_W-1:0] MIN_S = ACC_W'(MOTOR_MIN);
  localparam logic signed [ACC_W-1:0] MAX_S = ACC_W'(MOTOR_MAX);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_nxt;
  logic signed [ACC_W-1:0] opx;

  assign opx = {{(ACC_W-AXIS_W){operand[AXIS_W-1]}}, operand};

  always_comb begin
    acc_nxt = acc;
    if (load)
      acc_nxt = {{(ACC_W-OUT_W){1'b0}}, thr};
    else if (sub)
      acc_nxt = acc - opx;
    else
      acc_nxt = acc + opx;
  end

  always_ff @(posedge clk) begin
    if (rst)
      acc <= '0;
    else if (en)
      acc <= acc_nxt;
  end

  always_comb begin
    sat_next = acc_nxt[OUT_W-1:0];
    if (acc_nxt < MIN_S)
      sat_next = OUT_W'(MOTOR_MIN);
    else if (acc_nxt > MAX_S)
      sat_next = OUT_W'(MOTOR_MAX);
  end

endmodule

// File: rtl/motor_mix_sequencer.sv
// Quad-X mixer: one shared accumulator sequenced over 4 motors x 4 axes,
// with arming, commit of all four commands and receiver-loss failsafe.
module motor_mix_sequencer
  import drone_mix_pkg::*;
#(
  parameter int AXIS_W         = 12,
  parameter int OUT_W          = 11,
  parameter int MOTOR_MIN      = 100,
  parameter int MOTOR_MAX      = 2000,
  parameter int FAILSAFE_CMD   = 100,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arm,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OUT_W-1:0]         throttle_offset,
  input  logic signed [AXIS_W-1:0] pitch_offset,
  input  logic signed [AXIS_W-1:0] roll_offset,
  input  logic signed [AXIS_W-1:0] yaw_offset,
  output logic [OUT_W-1:0]         motor_1_cmd,
  output logic [OUT_W-1:0]         motor_2_cmd,
  output logic [OUT_W-1:0]         motor_3_cmd,
  output logic [OUT_W-1:0]         motor_4_cmd,
  output logic                     out_valid,
  output logic                     failsafe,
  output logic                     busy
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);
  localparam logic [OUT_W-1:0] FS_CMD = OUT_W'(FAILSAFE_CMD);

  state_t state;
  logic [WD_W-1:0] wd;
  logic [3:0] idx;
  logic [1:0] m_idx;
  logic [1:0] a_idx;
  logic accept;

  logic [OUT_W-1:0]         thr_q;
  logic signed [AXIS_W-1:0] p_q;
  logic signed [AXIS_W-1:0] r_q;
  logic signed [AXIS_W-1:0] y_q;

  logic [3:0][OUT_W-1:0] shadow;
  logic [3:0][OUT_W-1:0] cmd;

  logic signed [AXIS_W-1:0] operand;
  logic sub;
  logic acc_en;
  logic [OUT_W-1:0] sat_next;

  assign m_idx = idx[3:2];
  assign a_idx = idx[1:0];

  assign in_ready = (state == ST_DISARMED) ||
                    (state == ST_IDLE) ||
                    (state == ST_FAILSAFE);
  assign busy   = (state == ST_MIX);
  assign accept = in_valid && in_ready;
  assign acc_en = (state == ST_MIX) && arm;

  assign motor_1_cmd = cmd[0];
  assign motor_2_cmd = cmd[1];
  assign motor_3_cmd = cmd[2];
  assign motor_4_cmd = cmd[3];

  always_comb begin
    operand = '0;
    sub     = 1'b0;
    unique case (a_idx)
      AX_P: begin
        operand = p_q;
        sub     = SIGN_SUB[m_idx][0];
      end
      AX_R: begin
        operand = r_q;
        sub     = SIGN_SUB[m_idx][1];
      end
      AX_Y: begin
        operand = y_q;
        sub     = SIGN_SUB[m_idx][2];
      end
      default: ;
    endcase
  end

  mix_sat_accum #(
    .AXIS_W    (AXIS_W),
    .OUT_W     (OUT_W),
    .MOTOR_MIN (MOTOR_MIN),
    .MOTOR_MAX (MOTOR_MAX)
  ) u_accum (
    .clk      (clk),
    .rst      (rst),
    .en       (acc_en),
    .load     (a_idx == AX_T),
    .sub      (sub),
    .thr      (thr_q),
    .operand  (operand),
    .sat_next (sat_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_DISARMED;
      wd        <= '0;
      idx       <= '0;
      cmd       <= '0;
      shadow    <= '0;
      out_valid <= 1'b0;
      failsafe  <= 1'b0;
      thr_q     <= '0;
      p_q       <= '0;
      r_q       <= '0;
      y_q       <= '0;
    end else begin
      out_valid <= 1'b0;
      if (!arm) begin
        // Disarm beats everything; a running mix is abandoned.
        state    <= ST_DISARMED;
        wd       <= '0;
        idx      <= '0;
        cmd      <= '0;
        shadow   <= '0;
        failsafe <= 1'b0;
      end else begin
        if (accept)
          wd <= '0;
        else if (wd != WD_MAX)
          wd <= wd + 1'b1;

        case (state)
          ST_DISARMED: begin
            state <= ST_IDLE;
            wd    <= '0;
          end
          ST_IDLE: begin
            if (accept) begin
              thr_q <= throttle_offset;
              p_q   <= pitch_offset;
              r_q   <= roll_offset;
              y_q   <= yaw_offset;
              idx   <= '0;
              state <= ST_MIX;
            end else if (wd == WD_MAX) begin
              cmd      <= {4{FS_CMD}};
              failsafe <= 1'b1;
              state    <= ST_FAILSAFE;
            end
          end
          ST_MIX: begin
            idx <= idx + 1'b1;
            if (a_idx == AX_Y)
              shadow[m_idx] <= sat_next;
            if (idx == 4'd15)
              state <= ST_COMMIT;
          end
          ST_COMMIT: begin
            cmd       <= shadow;
            out_valid <= 1'b1;
            failsafe  <= 1'b0;
            state     <= ST_IDLE;
          end
          ST_FAILSAFE: begin
            if (accept) begin
              thr_q <= throttle_offset;
              p_q   <= pitch_offset;
              r_q   <= roll_offset;
              y_q   <= yaw_offset;
              idx   <= '0;
              state <= ST_MIX;
            end
          end
          default: state <= ST_DISARMED;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_motor_mix_sequencer.sv
// Directed self-checking bench for motor_mix_sequencer.
// Hand-computed mixes, latency, failsafe timing, disarm and backpressure.
module tb_motor_mix_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic arm;
  logic in_valid;
  logic in_ready;
  logic [10:0] throttle;
  logic signed [11:0] pitch;
  logic signed [11:0] roll;
  logic signed [11:0] yaw;
  logic [10:0] m1, m2, m3, m4;
  logic out_valid;
  logic failsafe;
  logic busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  motor_mix_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .arm             (arm),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .throttle_offset (throttle),
    .pitch_offset    (pitch),
    .roll_offset     (roll),
    .yaw_offset      (yaw),
    .motor_1_cmd     (m1),
    .motor_2_cmd     (m2),
    .motor_3_cmd     (m3),
    .motor_4_cmd     (m4),
    .out_valid       (out_valid),
    .failsafe        (failsafe),
    .busy            (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input int t, input int p, input int r, input int y);
    throttle = 11'(t);
    pitch    = 12'(p);
    roll     = 12'(r);
    yaw      = 12'(y);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    throttle = 11'd0;
    pitch    = 12'sd1234;
    roll     = -12'sd999;
    yaw      = 12'sd777;
  endtask

  task automatic wait_out(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!out_valid && n < 40);
    chk({tag, "_latency"}, n, 17);
  endtask

  task automatic chk_cmds(input string tag, input int e1, input int e2,
                          input int e3, input int e4);
    chk({tag, "_m1"}, 32'(m1), e1);
    chk({tag, "_m2"}, 32'(m2), e2);
    chk({tag, "_m3"}, 32'(m3), e3);
    chk({tag, "_m4"}, 32'(m4), e4);
  endtask

  initial begin
    int nov, na, a0, a1, nbad;
    rst = 1'b1;
    arm = 1'b0;
    in_valid = 1'b0;
    throttle = '0;
    pitch = '0;
    roll = '0;
    yaw = '0;
    tick();
    tick();
    rst = 1'b0;
    chk_cmds("reset", 0, 0, 0, 0);
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_failsafe", 32'(failsafe), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_in_ready", 32'(in_ready), 1);

    arm = 1'b1;
    tick();
    send(1000, 100, 50, 20);
    chk("mix_busy", 32'(busy), 1);
    chk("mix_in_ready", 32'(in_ready), 0);
    wait_out("f1");
    chk_cmds("f1", 1130, 1070, 830, 970);
    chk("f1_in_ready", 32'(in_ready), 1);
    chk("f1_failsafe", 32'(failsafe), 0);
    tick();
    chk("f1_pulse", 32'(out_valid), 0);

    send(1990, 100, 100, 0);
    wait_out("f2");
    chk_cmds("f2", 2000, 1990, 1790, 1990);

    send(50, -200, 0, 0);
    wait_out("f3");
    chk_cmds("f3", 100, 100, 250, 250);

    send(50, 200, 0, 0);
    wait_out("f4");
    chk_cmds("f4", 250, 250, 100, 100);

    // Watchdog expiry: 1000 counted cycles, then one IDLE cycle at timeout.
    send(600, 0, 0, 0);
    wait_out("f5");
    chk_cmds("f5", 600, 600, 600, 600);
    repeat (983) tick();
    chk("pre_timeout_failsafe", 32'(failsafe), 0);
    chk("pre_timeout_m1", 32'(m1), 600);
    tick();
    chk("timeout_failsafe", 32'(failsafe), 1);
    chk_cmds("timeout", 100, 100, 100, 100);
    chk("fs_in_ready", 32'(in_ready), 1);
    send(500, 0, 0, 0);
    chk("fs_mix_failsafe", 32'(failsafe), 1);
    chk("fs_mix_m1", 32'(m1), 100);
    wait_out("f6");
    chk_cmds("f6", 500, 500, 500, 500);
    chk("f6_failsafe", 32'(failsafe), 0);

    // Frame presented in the exact timeout cycle wins.
    repeat (983) tick();
    send(700, 0, 0, 0);
    chk("edge_failsafe", 32'(failsafe), 0);
    chk("edge_busy", 32'(busy), 1);
    wait_out("f7");
    chk_cmds("f7", 700, 700, 700, 700);
    chk("f7_failsafe", 32'(failsafe), 0);

    // Disarm in the middle of a mix.
    send(900, 10, 10, 10);
    repeat (7) tick();
    arm = 1'b0;
    tick();
    chk_cmds("disarm", 0, 0, 0, 0);
    chk("disarm_out_valid", 32'(out_valid), 0);
    chk("disarm_in_ready", 32'(in_ready), 1);
    chk("disarm_busy", 32'(busy), 0);
    nov = 0;
    send(1500, 0, 0, 0);
    if (out_valid) nov++;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (out_valid) nov++;
    end
    chk("disarmed_out_valid_count", nov, 0);
    chk("disarmed_m1", 32'(m1), 0);

    // Continuous in_valid: one acceptance per 18 cycles.
    arm = 1'b1;
    tick();
    throttle = 11'd800;
    pitch = '0;
    roll = '0;
    yaw = '0;
    in_valid = 1'b1;
    na = 0;
    a0 = 0;
    a1 = 0;
    nov = 0;
    nbad = 0;
    for (int e = 0; e < 60; e++) begin
      if (in_ready) begin
        if (na == 0) a0 = e;
        else if (na == 1) a1 = e;
        na++;
      end
      if (busy && in_ready) nbad++;
      tick();
      if (out_valid) nov++;
    end
    in_valid = 1'b0;
    chk("stream_accepts", na, 4);
    chk("stream_spacing", a1 - a0, 18);
    chk("stream_out_valid", nov, 3);
    chk("stream_ready_in_mix", nbad, 0);
    chk("stream_m1", 32'(m1), 800);

    // Reset during a mix.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_cmds("midrst", 0, 0, 0, 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
